// File: rtl/ram_256x16a.sv
// Single-port synchronous SRAM model (DEPTH x DATA_WIDTH) with a registered read port.
// Define RAM_PARITY_EN to add per-word even parity storage and the PERR flag.
module ram_256x16a #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  WEN,
  input  logic                  CEN,
`ifdef RAM_PARITY_EN
  output logic                  PERR,
`endif
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  wr_en;

  assign idx = A[IDX_W-1:0];

  // Addresses past DEPTH exist only when the array does not fill the address space.
  if (DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
    assign in_range = (A < ADDR_WIDTH'(DEPTH));
  end else begin : g_full
    assign in_range = 1'b1;
  end

  assign rd_data = mem_q[idx];
  assign wr_en   = !RST && !CEN && !WEN && in_range;

  // Storage array carries no reset so it maps onto a RAM macro.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[idx] <= D;
    end
  end

  always_comb begin
    q_d = q_q;
`ifndef SYNTHESIS
    if ($isunknown({CEN, WEN})) begin
      q_d = 'x;
    end else
`endif
    if (!CEN) begin
      if (!WEN) begin
        q_d = D;
      end else if (in_range) begin
        q_d = rd_data;
      end else begin
        q_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifdef RAM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic perr_q, perr_d;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      par_mem_q[idx] <= ^D;
    end
  end

  // Flag is only raised by an in-range read; every other cycle clears it.
  always_comb begin
    perr_d = 1'b0;
    if (!CEN && WEN && in_range) begin
      perr_d = (^rd_data) ^ par_mem_q[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign PERR = perr_q;
`endif

endmodule

// File: tb/tb_ram_256x16a.sv
// Scoreboard bench for ram_256x16a: driver pushes model-predicted Q per cycle, monitor pops and compares.
module tb_ram_256x16a;

  logic        CLK = 1'b0;
  logic        RST, WEN, CEN;
  logic [7:0]  A;
  logic [15:0] D;
  logic [15:0] Q;
`ifdef RAM_PARITY_EN
  logic        PERR;
`endif

  always #5 CLK = ~CLK;

  ram_256x16a dut (
    .CLK  (CLK),
    .RST  (RST),
    .A    (A),
    .D    (D),
    .WEN  (WEN),
    .CEN  (CEN),
`ifdef RAM_PARITY_EN
    .PERR (PERR),
`endif
    .Q    (Q)
  );

  typedef struct {
    logic [15:0] q;
    logic        perr;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [256];
  logic        ref_par [256];
  logic [15:0] m_q    = 16'h0000;
  logic        m_perr = 1'b0;
  int          n_chk  = 0;
  int          n_pass = 0;

  // One clock of stimulus; the reference result for that edge is queued after it.
  task automatic cyc(input logic rst, input logic cen, input logic wen,
                     input logic [7:0] a, input logic [15:0] d, input string tag);
    exp_t e;
    RST = rst; CEN = cen; WEN = wen; A = a; D = d;
    @(posedge CLK);
    if (rst) begin
      m_q    = 16'h0000;
      m_perr = 1'b0;
    end else if (!cen) begin
      if (!wen) begin
        ref_mem[a] = d;
        ref_par[a] = ^d;
        m_q        = d;
        m_perr     = 1'b0;
      end else begin
        m_q    = ref_mem[a];
        m_perr = (^ref_mem[a]) ^ ref_par[a];
      end
    end else begin
      m_perr = 1'b0;
    end
    e.q = m_q; e.perr = m_perr; e.tag = tag;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_chk++;
      if (Q !== mon_e.q)
        $display("FAIL %s: Q=%h expected %h", mon_e.tag, Q, mon_e.q);
      else
        n_pass++;
`ifdef RAM_PARITY_EN
      n_chk++;
      if (PERR !== mon_e.perr)
        $display("FAIL %s_perr: PERR=%b expected %b", mon_e.tag, PERR, mon_e.perr);
      else
        n_pass++;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CEN = 1'b1; WEN = 1'b1; A = 8'h00; D = 16'h0000;
    #1;
    cyc(1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, "init_rst");

    // Reset drops a concurrent write and clears Q; stored data survives.
    cyc(1'b0, 1'b0, 1'b0, 8'h05, 16'h1357, "wr05");
    cyc(1'b1, 1'b0, 1'b0, 8'h05, 16'hFFFF, "rst_a");
    cyc(1'b1, 1'b0, 1'b0, 8'h05, 16'hFFFF, "rst_b");
    cyc(1'b0, 1'b0, 1'b1, 8'h05, 16'h0000, "rd05");

    cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'hA5A5, "wr00");
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, 16'h5A5A, "wrFF");
    cyc(1'b0, 1'b0, 1'b0, 8'h80, 16'h1234, "wr80");
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, "rd00");
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, "rdFF");
    cyc(1'b0, 1'b0, 1'b1, 8'h80, 16'h0000, "rd80");

    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 1'b0, 8'h80, 16'h0000, "cen_hold");
    cyc(1'b0, 1'b0, 1'b1, 8'h80, 16'h0000, "rd80_after_cen");

    for (int i = 0; i < 256; i++)
      cyc(1'b0, 1'b0, 1'b0, 8'(i), 16'h0100 + 16'(i), "sweep_wr");
    for (int i = 0; i < 256; i++)
      cyc(1'b0, 1'b0, 1'b1, 8'(i), 16'h0000, "sweep_rd");

    cyc(1'b0, 1'b0, 1'b0, 8'h10, 16'hBEEF, "wr10");
    cyc(1'b0, 1'b0, 1'b1, 8'h10, 16'h0000, "rd10");

    for (int i = 0; i < 32; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      cyc(1'b0, 1'b0, 1'b0, a, 16'($urandom), "alt_wr");
      cyc(1'b0, 1'b0, 1'b1, a, 16'($urandom), "alt_rd");
    end

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), "rand");

`ifdef RAM_PARITY_EN
    cyc(1'b0, 1'b0, 1'b0, 8'h20, 16'h0001, "par_wr");
    cyc(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, "par_rd_ok");
    dut.mem_q[8'h20][0] = ~dut.mem_q[8'h20][0];
    ref_mem[8'h20][0]   = ~ref_mem[8'h20][0];
    cyc(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, "par_rd_bad");
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 16'h0000, "par_idle");
`endif

    cyc(1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, "tail_idle");
    @(negedge CLK);
    @(negedge CLK);
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
